// File: rtl/decode_stage.sv
// decode_stage: decode / operand-issue stage sitting between fetch and execute.
// Decodes ADD/SUB/LDB/LDW/STB/STW/BEQ/JUMP, reads the register file (whose write
// port belongs to writeback), tracks pending destination writes on a busy
// scoreboard to stall on RAW hazards, and holds the issued operands in a
// registered issue slot with a valid/ready handshake on both sides.
// Optional feature macro: WB_BYPASS_EN (forward same-cycle writeback data to
// operand reads and treat the busy bit being cleared as resolved).
module decode_stage #(
   parameter int ARCH_BITS = 32,
   parameter int REG_COUNT = 32,
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [ARCH_BITS-1:0] in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [6:0]           out_opcode,
   output logic [ARCH_BITS-1:0] out_data1,
   output logic [ARCH_BITS-1:0] out_data2,
   output logic [ARCH_BITS-1:0] out_store,
   output logic [ADDR_BITS-1:0] out_rd,
   output logic                 out_wr,
   output logic [ARCH_BITS-1:0] out_pc,
   output logic                 out_illegal,
   input  logic                 flush,
   input  logic                 wb_en,
   input  logic [ADDR_BITS-1:0] wb_addr,
   input  logic [ARCH_BITS-1:0] wb_data
);

   localparam logic [6:0] OP_ADD  = 7'h00;
   localparam logic [6:0] OP_SUB  = 7'h01;
   localparam logic [6:0] OP_LDB  = 7'h10;
   localparam logic [6:0] OP_LDW  = 7'h11;
   localparam logic [6:0] OP_STB  = 7'h12;
   localparam logic [6:0] OP_STW  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h30;
   localparam logic [6:0] OP_JUMP = 7'h31;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Instruction fields
   logic [6:0]           fOp;
   logic [ADDR_BITS-1:0] fRd;
   logic [ADDR_BITS-1:0] fRa;
   logic [ADDR_BITS-1:0] fRb;
   logic [14:0]          fImm;
   logic [ARCH_BITS-1:0] sext;

   assign fOp  = in_instr[31:25];
   assign fRd  = in_instr[24:20];
   assign fRa  = in_instr[19:15];
   assign fRb  = in_instr[14:10];
   assign fImm = in_instr[14:0];
   assign sext = {{(ARCH_BITS-15){fImm[14]}}, fImm};

   // Architectural state
   logic [ARCH_BITS-1:0] regs_q [REG_COUNT];
   logic [REG_COUNT-1:0] busy_q;
   logic [REG_COUNT-1:0] busy_d;

   // Issue register
   logic                 issueValid_q;
   logic [6:0]           issueOp_q;
   logic [ARCH_BITS-1:0] issueData1_q;
   logic [ARCH_BITS-1:0] issueData2_q;
   logic [ARCH_BITS-1:0] issueStore_q;
   logic [ADDR_BITS-1:0] issueRd_q;
   logic                 issueWr_q;
   logic [ARCH_BITS-1:0] issuePc_q;
   logic                 issueIllegal_q;

   // Operand read ports: ra, rb and rd (rd is read as store data)
   logic                 bypA, bypB, bypD;
   logic [ARCH_BITS-1:0] valA, valB, valD;

   assign bypA = BYPASS && wb_en && (wb_addr == fRa) && (fRa != '0);
   assign bypB = BYPASS && wb_en && (wb_addr == fRb) && (fRb != '0);
   assign bypD = BYPASS && wb_en && (wb_addr == fRd) && (fRd != '0);

   assign valA = (fRa == '0) ? '0 : (bypA ? wb_data : regs_q[fRa]);
   assign valB = (fRb == '0) ? '0 : (bypB ? wb_data : regs_q[fRb]);
   assign valD = (fRd == '0) ? '0 : (bypD ? wb_data : regs_q[fRd]);

   // Decoded operands and which register fields this opcode really reads
   logic                 useA, useB, useD;
   logic [ARCH_BITS-1:0] decData1, decData2, decStore;
   logic                 decWr, decIllegal;

   // Map the opcode to the operand bundle handed to execute
   always_comb begin
      useA       = 1'b0;
      useB       = 1'b0;
      useD       = 1'b0;
      decData1   = '0;
      decData2   = '0;
      decStore   = '0;
      decWr      = 1'b0;
      decIllegal = 1'b0;
      case (fOp)
         OP_ADD, OP_SUB: begin
            useA     = 1'b1;
            useB     = 1'b1;
            decData1 = valA;
            decData2 = valB;
            decWr    = 1'b1;
         end
         OP_LDB, OP_LDW: begin
            useA     = 1'b1;
            decData1 = valA;
            decData2 = sext;
            decWr    = 1'b1;
         end
         OP_STB, OP_STW: begin
            useA     = 1'b1;
            useD     = 1'b1;
            decData1 = valA;
            decData2 = sext;
            decStore = valD;
         end
         OP_BEQ: begin
            useA     = 1'b1;
            useB     = 1'b1;
            decData1 = in_pc;
            decData2 = sext << 2;
            decStore = valB;
         end
         OP_JUMP: begin
            useA     = 1'b1;
            decData1 = valA;
            decData2 = sext;
         end
         default: begin
            decIllegal = 1'b1;
         end
      endcase
   end

   // A source still waiting for its producer blocks issue; a bypassed one does not
   logic hazard;
   logic accept;

   assign hazard = (useA && busy_q[fRa] && !bypA) ||
                   (useB && busy_q[fRb] && !bypB) ||
                   (useD && busy_q[fRd] && !bypD);

   assign in_ready = rst && !flush && (!issueValid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // Scoreboard next state: clears from writeback and from a killed writer, then set wins
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (flush && issueValid_q && issueWr_q) begin
         busy_d[issueRd_q] = 1'b0;
      end
      if (accept && decWr && (fRd != '0)) begin
         busy_d[fRd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Register file write port; r0 writes are dropped so it always reads zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   // Issue slot: load on accept, drop on consume or flush, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issueValid_q   <= 1'b0;
         issueOp_q      <= '0;
         issueData1_q   <= '0;
         issueData2_q   <= '0;
         issueStore_q   <= '0;
         issueRd_q      <= '0;
         issueWr_q      <= 1'b0;
         issuePc_q      <= '0;
         issueIllegal_q <= 1'b0;
      end else if (flush) begin
         issueValid_q <= 1'b0;
      end else if (accept) begin
         issueValid_q   <= 1'b1;
         issueOp_q      <= fOp;
         issueData1_q   <= decData1;
         issueData2_q   <= decData2;
         issueStore_q   <= decStore;
         issueRd_q      <= fRd;
         issueWr_q      <= decWr;
         issuePc_q      <= in_pc;
         issueIllegal_q <= decIllegal;
      end else if (out_ready) begin
         issueValid_q <= 1'b0;
      end
   end

   assign out_valid   = issueValid_q;
   assign out_opcode  = issueOp_q;
   assign out_data1   = issueData1_q;
   assign out_data2   = issueData2_q;
   assign out_store   = issueStore_q;
   assign out_rd      = issueRd_q;
   assign out_wr      = issueWr_q;
   assign out_pc      = issuePc_q;
   assign out_illegal = issueIllegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Stimulus predicts each
// accepted instruction's issue bundle from the ISA rules and queues it; an
// independent monitor compares the DUT's issue register against the queue.
// Build with WB_BYPASS_EN defined to check the bypass configuration.
module tb_decode_stage;

   localparam logic [6:0] OP_ADD  = 7'h00;
   localparam logic [6:0] OP_SUB  = 7'h01;
   localparam logic [6:0] OP_LDB  = 7'h10;
   localparam logic [6:0] OP_LDW  = 7'h11;
   localparam logic [6:0] OP_STB  = 7'h12;
   localparam logic [6:0] OP_STW  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h30;
   localparam logic [6:0] OP_JUMP = 7'h31;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [6:0]  out_opcode;
   logic [31:0] out_data1;
   logic [31:0] out_data2;
   logic [31:0] out_store;
   logic [4:0]  out_rd;
   logic        out_wr;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic        flush = 1'b0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;

   decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_data1(out_data1), .out_data2(out_data2),
      .out_store(out_store), .out_rd(out_rd), .out_wr(out_wr), .out_pc(out_pc),
      .out_illegal(out_illegal), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  opcode;
      logic [31:0] data1;
      logic [31:0] data2;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] pc;
      logic        illegal;
   } expT;

   expT         expQ[$];
   logic [31:0] mRegs[32];
   bit          mBusy[32];
   int          pending[$];
   int          total = 0;
   int          bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mRead(input int idx, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
      if (idx == 0) return 32'h0;
      if (BYPASS && we && (int'(wa) == idx)) return wd;
      return mRegs[idx];
   endfunction

   // Reference decode: what the issue slot must hold if this word is accepted
   function automatic void mPredict(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                    output expT e, output bit haz);
      logic [6:0]  op;
      int          rd, ra, rb, s;
      logic [31:0] sx;
      int          srcs[$];
      op = instr[31:25];
      rd = int'(instr[24:20]);
      ra = int'(instr[19:15]);
      rb = int'(instr[14:10]);
      s  = int'(instr[14:0]);
      if (instr[14]) s = s - 32768;
      sx = 32'(s);
      e.opcode  = op;
      e.data1   = 32'h0;
      e.data2   = 32'h0;
      e.store   = 32'h0;
      e.rd      = instr[24:20];
      e.wr      = 1'b0;
      e.pc      = pc;
      e.illegal = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            srcs.push_back(ra); srcs.push_back(rb);
            e.data1 = mRead(ra, we, wa, wd);
            e.data2 = mRead(rb, we, wa, wd);
            e.wr    = 1'b1;
         end
         OP_LDB, OP_LDW: begin
            srcs.push_back(ra);
            e.data1 = mRead(ra, we, wa, wd);
            e.data2 = sx;
            e.wr    = 1'b1;
         end
         OP_STB, OP_STW: begin
            srcs.push_back(ra); srcs.push_back(rd);
            e.data1 = mRead(ra, we, wa, wd);
            e.data2 = sx;
            e.store = mRead(rd, we, wa, wd);
         end
         OP_BEQ: begin
            srcs.push_back(ra); srcs.push_back(rb);
            e.data1 = pc;
            e.data2 = 32'(sx * 4);
            e.store = mRead(rb, we, wa, wd);
         end
         OP_JUMP: begin
            srcs.push_back(ra);
            e.data1 = mRead(ra, we, wa, wd);
            e.data2 = sx;
         end
         default: e.illegal = 1'b1;
      endcase
      haz = 1'b0;
      foreach (srcs[i]) begin
         if (srcs[i] != 0 && mBusy[srcs[i]] && !(BYPASS && we && int'(wa) == srcs[i])) haz = 1'b1;
      end
   endfunction

   // One clock of stimulus: drive, check in_ready against the model, then advance the model
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                output bit accepted, output logic dutReady);
      expT        e;
      bit         haz, expReady, hadKill;
      logic [4:0] killRd;
      logic       killWr;
      @(negedge clk);
      in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      mPredict(instr, pc, we, wa, wd, e, haz);
      expReady = !fl && ((expQ.size() == 0) || ordy) && !haz;
      dutReady = in_ready;
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      accepted = v && expReady;
      hadKill = fl && (expQ.size() != 0);
      killRd = '0;
      killWr = 1'b0;
      if (hadKill) begin
         killRd = expQ[0].rd;
         killWr = expQ[0].wr;
      end
      if (expQ.size() != 0 && ordy && !fl && expQ[0].wr && expQ[0].rd != 0)
         pending.push_back(int'(expQ[0].rd));
      @(posedge clk);
      if (we) mBusy[wa] = 1'b0;
      if (hadKill && killWr) mBusy[killRd] = 1'b0;
      if (accepted && e.wr && e.rd != 0) mBusy[e.rd] = 1'b1;
      if (we && wa != 0) mRegs[wa] = wd;
      if (accepted) expQ.push_back(e);
   endtask

   // Assert reset mid-cycle, check the stage goes quiet, and wipe the model
   task automatic doReset();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
      #1;
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset in_ready", 32'(in_ready), 32'h0);
      expQ.delete();
      pending.delete();
      for (int i = 0; i < 32; i++) begin
         mRegs[i] = 32'h0;
         mBusy[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Retire every outstanding destination so a directed test starts hazard-free
   task automatic wbAll();
      bit   acc;
      logic rdy;
      for (int i = 1; i < 32; i++) begin
         if (mBusy[i]) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'(i), $urandom, acc, rdy);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int ra, input int rb);
      return {op, 5'(rd), 5'(ra), 5'(rb), 10'h0};
   endfunction

   // Monitor: whenever the issue slot is presented, it must match the oldest expectation
   always @(negedge clk) begin
      #2;
      if (rst) begin
         checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
         if (out_valid && expQ.size() != 0) begin
            checkOutput("out_opcode", 32'(out_opcode), 32'(expQ[0].opcode));
            checkOutput("out_data1", out_data1, expQ[0].data1);
            checkOutput("out_data2", out_data2, expQ[0].data2);
            checkOutput("out_pc", out_pc, expQ[0].pc);
            checkOutput("out_wr", 32'(out_wr), 32'(expQ[0].wr));
            checkOutput("out_illegal", 32'(out_illegal), 32'(expQ[0].illegal));
            if (expQ[0].wr) checkOutput("out_rd", 32'(out_rd), 32'(expQ[0].rd));
            if (expQ[0].opcode inside {OP_STB, OP_STW, OP_BEQ})
               checkOutput("out_store", out_store, expQ[0].store);
            if (out_ready || flush) void'(expQ.pop_front());
         end
      end
   end

   // Directed scenarios followed by a randomized run
   initial begin
      bit          acc;
      logic        rdy;
      logic [31:0] instr;
      logic [6:0]  op;
      logic        v, ordy, fl, we;
      logic [4:0]  wa;
      logic [31:0] wd;

      doReset();

      // Basic ADD after two writebacks
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5, acc, rdy);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd3, acc, rdy);
      applyStimulus(1'b1, mk(OP_ADD, 3, 1, 2), 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      #2;
      checkOutput("add valid", 32'(out_valid), 32'h1);
      checkOutput("add data1", out_data1, 32'd5);
      checkOutput("add data2", out_data2, 32'd3);
      checkOutput("add rd", 32'(out_rd), 32'd3);

      // Sign-extended load, then a dependent ADD waiting on its writeback
      applyStimulus(1'b1, {OP_LDW, 5'd4, 5'd1, 15'h7FFF}, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      #2;
      checkOutput("ldw data2", out_data2, 32'hFFFF_FFFF);
      applyStimulus(1'b1, mk(OP_ADD, 5, 4, 4), 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("raw stall ready", 32'(rdy), 32'h0);
      applyStimulus(1'b1, mk(OP_ADD, 5, 4, 4), 32'h108, 1'b1, 1'b0, 1'b1, 5'd4, 32'h1234, acc, rdy);
      checkOutput("wb cycle ready", 32'(rdy), 32'(BYPASS));
      if (!acc) begin
         applyStimulus(1'b1, mk(OP_ADD, 5, 4, 4), 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
         checkOutput("after wb ready", 32'(rdy), 32'h1);
      end
      #2;
      checkOutput("dep data1", out_data1, 32'h1234);
      checkOutput("dep data2", out_data2, 32'h1234);

      // Backpressure holds the slot, then back-to-back issue
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, mk(OP_SUB, 9, 1, 2), 32'h10C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
         checkOutput("hold ready", 32'(rdy), 32'h0);
         #2;
         checkOutput("hold data1", out_data1, 32'h1234);
      end
      applyStimulus(1'b1, mk(OP_SUB, 9, 1, 2), 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("release ready", 32'(rdy), 32'h1);
      #2;
      checkOutput("release opcode", 32'(out_opcode), 32'(OP_SUB));
      applyStimulus(1'b1, mk(OP_ADD, 10, 1, 2), 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("b2b ready", 32'(rdy), 32'h1);

      // Flush kills ADD r6 and releases its busy bit
      wbAll();
      applyStimulus(1'b1, mk(OP_ADD, 6, 1, 2), 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("flush ready", 32'(rdy), 32'h0);
      #2;
      checkOutput("flush valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b1, mk(OP_SUB, 7, 6, 6), 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("post-flush ready", 32'(rdy), 32'h1);

      // Illegal opcode, and r0 as destination and source
      applyStimulus(1'b1, {7'h7F, 5'd9, 5'd1, 5'd2, 10'h3FF}, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      #2;
      checkOutput("illegal flag", 32'(out_illegal), 32'h1);
      checkOutput("illegal wr", 32'(out_wr), 32'h0);
      checkOutput("illegal data1", out_data1, 32'h0);
      applyStimulus(1'b1, mk(OP_ADD, 0, 1, 2), 32'h120, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, acc, rdy);
      applyStimulus(1'b1, mk(OP_ADD, 11, 0, 0), 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      checkOutput("r0 no busy", 32'(rdy), 32'h1);
      #2;
      checkOutput("r0 reads zero", out_data1, 32'h0);

      // Reset in the middle of traffic
      applyStimulus(1'b1, mk(OP_ADD, 13, 1, 2), 32'h128, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      doReset();
      applyStimulus(1'b1, mk(OP_ADD, 8, 1, 2), 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      #2;
      checkOutput("reset r1", out_data1, 32'h0);

      // Randomized traffic with hazards, backpressure, flushes and writebacks
      for (int c = 0; c < 600; c++) begin
         case ($urandom_range(0, 8))
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_LDB;
            3: op = OP_LDW;
            4: op = OP_STB;
            5: op = OP_STW;
            6: op = OP_BEQ;
            7: op = OP_JUMP;
            default: op = 7'($urandom);
         endcase
         instr = $urandom;
         instr[31:25] = op;
         instr[24:20] = 5'($urandom_range(0, 7));
         instr[19:15] = 5'($urandom_range(0, 7));
         instr[13] = 1'b0;
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 15) == 0);
         we   = 1'b0;
         wa   = '0;
         wd   = $urandom;
         if (pending.size() != 0 && $urandom_range(0, 2) == 0) begin
            we = 1'b1;
            wa = 5'(pending.pop_front());
         end else if ($urandom_range(0, 7) == 0) begin
            we = 1'b1;
            wa = 5'($urandom_range(0, 7));
         end
         applyStimulus(v, instr, $urandom, ordy, fl, we, wa, wd, acc, rdy);
      end

      repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, acc, rdy);
      @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
